// File: rtl/de_interleaver.sv
// 802.11a block deinterleaver: ping-pong banks of MAXB bits, serial in/out, one bit per clock.
// Optional DEINT_FLUSH_EN: a full bank keeps draining after Start falls; a partial bank is dropped on restart.
module de_interleaver #(
    parameter int unsigned MAXB = 288
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       x,
    input  logic [3:0] Rate,
    output logic       y,
    output logic       Valid
);

    localparam int unsigned AW = $clog2(MAXB);

    // Mode codes: 0 = 48/1 (BPSK), 1 = 96/2 (QPSK), 2 = 192/4 (16-QAM), 3 = 288/6 (64-QAM)
    function automatic logic [1:0] decode_rate(input logic [3:0] r);
        logic [1:0] m;
        m = 2'd0;
        if (r[0]) begin
            case (r[3:2])
                2'b11:   m = 2'd0;
                2'b01:   m = 2'd1;
                2'b10:   m = 2'd2;
                default: m = 2'd3;
            endcase
        end
        return m;
    endfunction

    function automatic logic [AW-1:0] ncbps_of(input logic [1:0] m);
        logic [AW-1:0] n;
        case (m)
            2'd0:    n = AW'(48);
            2'd1:    n = AW'(96);
            2'd2:    n = AW'(192);
            default: n = AW'(288);
        endcase
        return n;
    endfunction

    logic [MAXB-1:0] bank [2];
    logic            sel;
    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   rcnt;
    logic [1:0]      wr_mode;
    logic [1:0]      rd_mode;
    logic            rd_active;

    logic            restart_c;
    logic            wzero_c;
    logic [AW-1:0]   waddr_c;
    logic [1:0]      cur_mode_c;
    logic            wlast_c;
    logic            rd_en_c;
    logic            rlast_c;
    logic [AW-1:0]   q_c;
    logic [AW-1:0]   r_c;
    logic [AW-1:0]   ilv_c;
    logic            rd_bit_c;

`ifdef DEINT_FLUSH_EN
    logic start_q;
    assign restart_c = Start & ~start_q;
    assign rd_en_c   = rd_active;
`else
    assign restart_c = 1'b0;
    assign rd_en_c   = rd_active & Start;
`endif

    // Write side: rate is sampled only on the first bit of a symbol
    assign wzero_c    = (wcnt == '0) | restart_c;
    assign waddr_c    = wzero_c ? '0 : wcnt;
    assign cur_mode_c = wzero_c ? decode_rate(Rate) : wr_mode;
    assign wlast_c    = (waddr_c == ncbps_of(cur_mode_c) - AW'(1));
    assign rlast_c    = (rcnt == ncbps_of(rd_mode) - AW'(1));

    // Read address: floor(16*i/NCBPS) collapses to k mod 16, so only tiny constant divides remain
    assign q_c = AW'(rcnt[AW-1:4]);
    assign r_c = AW'(rcnt[3:0]);

    always_comb begin
        ilv_c = '0;
        case (rd_mode)
            2'd0: ilv_c = r_c * AW'(3) + q_c;
            2'd1: ilv_c = r_c * AW'(6) + q_c;
            2'd2: begin
                ilv_c = r_c * AW'(12) + q_c;
                ilv_c[0] = ilv_c[0] ^ r_c[0];
            end
            default: ilv_c = r_c * AW'(18) + q_c - (q_c % AW'(3))
                             + ((q_c + AW'(15) - r_c) % AW'(3));
        endcase
    end

    assign rd_bit_c = bank[~sel][ilv_c];

    always_ff @(posedge Clk) begin
        if (Start) bank[sel][waddr_c] <= x;
    end

    // Counters, bank select and output; a write wrap overrides a coincident read wrap
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sel       <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            wr_mode   <= 2'd0;
            rd_mode   <= 2'd0;
            rd_active <= 1'b0;
            y         <= 1'b0;
            Valid     <= 1'b0;
`ifdef DEINT_FLUSH_EN
            start_q   <= 1'b0;
`endif
        end else begin
            Valid <= rd_en_c;
            if (rd_en_c) begin
                y <= rd_bit_c;
                if (rlast_c) begin
                    rcnt      <= '0;
                    rd_active <= 1'b0;
                end else begin
                    rcnt <= rcnt + AW'(1);
                end
            end
            if (Start) begin
                if (wzero_c) wr_mode <= cur_mode_c;
                if (wlast_c) begin
                    wcnt      <= '0;
                    sel       <= ~sel;
                    rd_mode   <= cur_mode_c;
                    rd_active <= 1'b1;
                    rcnt      <= '0;
                end else begin
                    wcnt <= waddr_c + AW'(1);
                end
            end
`ifdef DEINT_FLUSH_EN
            start_q <= Start;
`endif
        end
    end

endmodule

// File: tb/tb_de_interleaver.sv
// Scoreboard bench for de_interleaver: a golden 802.11a interleaver builds the input,
// the pre-interleave bits are queued and compared in order against y.
module tb_de_interleaver;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       x     = 1'b0;
    logic [3:0] Rate  = 4'b1101;
    logic       y;
    logic       Valid;

    de_interleaver dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .x     (x),
        .Rate  (Rate),
        .y     (y),
        .Valid (Valid)
    );

    always #5 Clk = ~Clk;

    int   checks          = 0;
    int   failures        = 0;
    int   cyc             = 0;
    int   vcount          = 0;
    int   v0              = 0;
    int   first_valid_cyc = -1;
    int   exp_first       = -1;
    bit   exp_q [$];
    logic start_q         = 1'b0;
    logic y_last          = 1'b0;

    always @(posedge Clk) begin
        cyc     <= cyc + 1;
        start_q <= Start;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Rate table straight from the 802.11a RATE field definition
    task automatic rate_params(input logic [3:0] r, output int n, output int nb);
        case (r)
            4'b1101, 4'b1111: begin n = 48;  nb = 1; end
            4'b0101, 4'b0111: begin n = 96;  nb = 2; end
            4'b1001, 4'b1011: begin n = 192; nb = 4; end
            4'b0001, 4'b0011: begin n = 288; nb = 6; end
            default:          begin n = 48;  nb = 1; end
        endcase
    endtask

    // Transmit-side interleaver: position in the symbol where coded bit k is sent
    function automatic int ipos(input int k, input int n, input int nb);
        int s, i;
        s = (nb / 2 > 1) ? nb / 2 : 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    // Monitor: every Valid pops one expected bit; idle cycles must hold y
    initial begin
        bit e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                y_last = 1'b0;
            end else begin
                if (Valid) begin
                    vcount++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    check("valid_without_start", int'(start_q), 1);
                    if (exp_q.size() == 0) begin
                        check("valid_with_empty_scoreboard", int'(Valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("y_bit", int'(y), int'(e));
                    end
                end else begin
                    check("y_hold", int'(y), int'(y_last));
                end
                y_last = y;
            end
        end
    end

    task automatic drive(input logic st, input logic xv, input logic [3:0] rt);
        @(negedge Clk);
        Start = st;
        x     = xv;
        Rate  = rt;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        Start = 1'b0;
        exp_q.delete();
        #1;
        check("reset_valid", int'(Valid), 0);
        check("reset_y", int'(y), 0);
        repeat (2) @(posedge Clk);
        #2;
        Reset           = 1'b1;
        v0              = vcount;
        first_valid_cyc = -1;
    endtask

    // One symbol: hot_k >= 0 makes the coded data one-hot; pause_at inserts 10 idle cycles
    task automatic run_sym(input logic [3:0] rt, input logic [3:0] rt_mid, input bit use_mid,
                           input int pause_at, input int hot_k, input int hot_pos, input bit lat);
        int n, nb, jp;
        bit data [288];
        bit xs [288];
        rate_params(rt, n, nb);
        for (int k = 0; k < n; k++)
            data[k] = (hot_k >= 0) ? (k == hot_k) : 1'($urandom_range(0, 1));
        for (int k = 0; k < n; k++) begin
            jp = ipos(k, n, nb);
            xs[jp] = data[k];
            if (k == hot_k) check("onehot_input_position", jp, hot_pos);
        end
        for (int k = 0; k < n; k++) exp_q.push_back(data[k]);
        for (int p = 0; p < n; p++) begin
            if (p == pause_at)
                repeat (10) drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
            drive(1'b1, xs[p], (use_mid && p >= n / 2) ? rt_mid : rt);
            if (lat && p == n - 1) exp_first = cyc + 2;
        end
    endtask

    task automatic end_phase(input int exp_valids, input int left);
        drive(1'b0, 1'b0, Rate);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        check("valid_count", vcount - v0, exp_valids);
        check("bits_left_unread", exp_q.size(), left);
        check("first_valid_edge", first_valid_cyc, exp_first);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // BPSK stream, 14 symbols (672 bits) including directed one-hot cases
        run_sym(4'b1101, 4'b1101, 1'b0, -1, -1, 0, 1'b1);
        run_sym(4'b1101, 4'b1101, 1'b0, -1, 16, 1, 1'b0);
        run_sym(4'b1101, 4'b1101, 1'b0, -1, 1, 3, 1'b0);
        for (int s = 0; s < 11; s++) run_sym(4'b1101, 4'b1101, 1'b0, -1, -1, 0, 1'b0);
        end_phase(13 * 48, 48);

        // Reset in the middle of a symbol
        for (int p = 0; p < 20; p++) drive(1'b1, 1'($urandom_range(0, 1)), 4'b1101);
        do_reset();

        // 16-QAM and 64-QAM maps
        run_sym(4'b1001, 4'b1001, 1'b0, -1, 1, 13, 1'b1);
        run_sym(4'b0001, 4'b0001, 1'b0, -1, 1, 20, 1'b0);
        run_sym(4'b0001, 4'b0001, 1'b0, -1, -1, 0, 1'b0);
        run_sym(4'b0011, 4'b0011, 1'b0, -1, -1, 0, 1'b0);
        end_phase(192 + 288 + 288, 288);

        // Rate change inside a symbol, then a 10-cycle Start pause mid-symbol
        do_reset();
        run_sym(4'b1101, 4'b0101, 1'b1, -1, -1, 0, 1'b1);
        run_sym(4'b0101, 4'b0101, 1'b0, -1, -1, 0, 1'b0);
        run_sym(4'b0101, 4'b0101, 1'b0, 30, -1, 0, 1'b0);
        run_sym(4'b0111, 4'b0111, 1'b0, -1, -1, 0, 1'b0);
        end_phase(48 + 96 + 96, 96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
